// File: rtl/xnor_match_counter.sv
// Masked XNOR word comparator with a two-state lock detector.
// Stage 1 registers the masked equality of A and B; stage 2 counts runs of
// consecutive matches, locks after THRESH of them and keeps a saturating total.
module xnor_match_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned THRESH    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_clr,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic [WIDTH-1:0]     i_m,
  output logic [WIDTH-1:0]     o_c,
  output logic                 o_eq,
  output logic                 o_vld,
  output logic [CNT_WIDTH-1:0] o_run_cnt,
  output logic [CNT_WIDTH-1:0] o_total_cnt,
  output logic                 o_locked,
  output logic                 o_hit,
  output logic                 o_lost
);

  typedef enum logic {StSearch, StLocked} state_e;

  localparam logic [CNT_WIDTH-1:0] MaxCnt   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] ThreshCnt = CNT_WIDTH'(THRESH);

  logic [WIDTH-1:0]     r_c;
  logic                 r_eq;
  logic                 r_vld;
  logic [CNT_WIDTH-1:0] r_run_cnt;
  logic [CNT_WIDTH-1:0] r_total_cnt;
  state_e               r_state;
  logic                 r_hit;
  logic                 r_lost;

  logic [WIDTH-1:0]     w_c;
  logic [CNT_WIDTH-1:0] w_run_inc;
  logic [CNT_WIDTH-1:0] w_total_inc;

  // Masked-off bits always read as equal.
  assign w_c         = ~(i_a ^ i_b) | ~i_m;
  assign w_run_inc   = (r_run_cnt == MaxCnt) ? r_run_cnt : r_run_cnt + CNT_WIDTH'(1);
  assign w_total_inc = (r_total_cnt == MaxCnt) ? r_total_cnt : r_total_cnt + CNT_WIDTH'(1);

  // Stage 1: capture comparison result; C/eq hold while en is low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_c   <= '0;
      r_eq  <= 1'b0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= i_en;
      if (i_en) begin
        r_c  <= w_c;
        r_eq <= &w_c;
      end
    end
  end

  // Stage 2: lock FSM and counters; vld=0 cycles are gaps that hold state.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_state     <= StSearch;
      r_run_cnt   <= '0;
      r_total_cnt <= '0;
      r_hit       <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      r_hit  <= 1'b0;
      r_lost <= 1'b0;
      if (r_vld) begin
        if (r_eq) begin
          r_run_cnt   <= w_run_inc;
          r_total_cnt <= w_total_inc;
          if (r_state == StSearch && w_run_inc == ThreshCnt) begin
            r_state <= StLocked;
            r_hit   <= 1'b1;
          end
        end else begin
          r_run_cnt <= '0;
          if (r_state == StLocked) begin
            r_state <= StSearch;
            r_lost  <= 1'b1;
          end
        end
      end
    end
  end

  assign o_c         = r_c;
  assign o_eq        = r_eq;
  assign o_vld       = r_vld;
  assign o_run_cnt   = r_run_cnt;
  assign o_total_cnt = r_total_cnt;
  assign o_locked    = (r_state == StLocked);
  assign o_hit       = r_hit;
  assign o_lost      = r_lost;

endmodule

// File: tb/tb_xnor_match_counter.sv
// Directed bench for xnor_match_counter: a default instance (CNT_WIDTH=8,
// THRESH=4) and a saturation instance (CNT_WIDTH=3, THRESH=7) on shared inputs.
module tb_xnor_match_counter;

  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [7:0] a, b, m;

  logic [7:0] c;
  logic       eq, vld, locked, hit, lost;
  logic [7:0] run_cnt, total_cnt;

  logic [7:0] c_s;
  logic       eq_s, vld_s, locked_s, hit_s, lost_s;
  logic [2:0] run_s, total_s;

  int n_checks = 0;
  int n_pass   = 0;
  int hits     = 0;
  int hits_s   = 0;

  always #5 clk = ~clk;

  xnor_match_counter #(.WIDTH(8), .CNT_WIDTH(8), .THRESH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr),
    .i_a(a), .i_b(b), .i_m(m),
    .o_c(c), .o_eq(eq), .o_vld(vld), .o_run_cnt(run_cnt), .o_total_cnt(total_cnt),
    .o_locked(locked), .o_hit(hit), .o_lost(lost)
  );

  xnor_match_counter #(.WIDTH(8), .CNT_WIDTH(3), .THRESH(7)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr),
    .i_a(a), .i_b(b), .i_m(m),
    .o_c(c_s), .o_eq(eq_s), .o_vld(vld_s), .o_run_cnt(run_s), .o_total_cnt(total_s),
    .o_locked(locked_s), .o_hit(hit_s), .o_lost(lost_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock and sample #1 later; tally hit pulses seen.
  task automatic cyc();
    @(posedge clk);
    #1;
    hits   += int'(hit);
    hits_s += int'(hit_s);
  endtask

  task automatic drive(input logic e, input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] vm);
    en = e; a = va; b = vb; m = vm;
  endtask

  task automatic match();
    drive(1'b1, 8'hA5, 8'hA5, 8'hFF);
    cyc();
  endtask

  task automatic gap();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    cyc();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    gap();
    clr = 1'b0;
    hits = 0;
    hits_s = 0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    cyc();
    cyc();
    check("rst_c", 32'(c), 32'h0);
    check("rst_eq", 32'(eq), 32'h0);
    check("rst_vld", 32'(vld), 32'h0);
    check("rst_run", 32'(run_cnt), 32'h0);
    check("rst_total", 32'(total_cnt), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_hit", 32'(hit), 32'h0);
    check("rst_lost", 32'(lost), 32'h0);
    rst = 1'b0;

    // XNOR and mask
    drive(1'b1, 8'hA5, 8'hA5, 8'hFF); cyc();
    check("eq_c", 32'(c), 32'hFF);
    check("eq_eq", 32'(eq), 32'h1);
    check("eq_vld", 32'(vld), 32'h1);
    drive(1'b1, 8'hA5, 8'h5A, 8'hFF); cyc();
    check("ne_c", 32'(c), 32'h00);
    check("ne_eq", 32'(eq), 32'h0);
    check("first_match_run", 32'(run_cnt), 32'h1);
    drive(1'b1, 8'hF0, 8'hFF, 8'hF0); cyc();
    check("mask_c", 32'(c), 32'hFF);
    check("mask_eq", 32'(eq), 32'h1);
    check("break_run", 32'(run_cnt), 32'h0);
    drive(1'b1, 8'hF0, 8'hFF, 8'hFF); cyc();
    check("nomask_c", 32'(c), 32'hF0);
    check("nomask_eq", 32'(eq), 32'h0);
    check("mask_total", 32'(total_cnt), 32'h2);
    drive(1'b1, 8'h12, 8'h34, 8'h00); cyc();
    check("fullmask_c", 32'(c), 32'hFF);
    check("fullmask_eq", 32'(eq), 32'h1);
    gap();
    check("gap_vld", 32'(vld), 32'h0);
    check("gap_c_hold", 32'(c), 32'hFF);
    check("fullmask_run", 32'(run_cnt), 32'h1);
    do_clr();
    check("clr_total", 32'(total_cnt), 32'h0);

    // Lock then lose
    for (int i = 0; i < 4; i++) match();
    check("prelock_run", 32'(run_cnt), 32'h3);
    check("prelock_locked", 32'(locked), 32'h0);
    gap();
    check("lock_hit", 32'(hit), 32'h1);
    check("lock_locked", 32'(locked), 32'h1);
    check("lock_run", 32'(run_cnt), 32'h4);
    check("lock_total", 32'(total_cnt), 32'h4);
    gap();
    check("hit_width", 32'(hit), 32'h0);
    check("lock_hold", 32'(locked), 32'h1);
    check("s_nolock", 32'(locked_s), 32'h0);
    drive(1'b1, 8'hA5, 8'h5A, 8'hFF); cyc();
    gap();
    check("lost_pulse", 32'(lost), 32'h1);
    check("lost_locked", 32'(locked), 32'h0);
    check("lost_run", 32'(run_cnt), 32'h0);
    check("lost_total", 32'(total_cnt), 32'h4);
    check("lost_nohit", 32'(hit), 32'h0);
    check("s_nolost", 32'(lost_s), 32'h0);
    gap();
    check("lost_width", 32'(lost), 32'h0);

    // Gaps do not break a run
    do_clr();
    match();
    gap(); gap(); gap();
    match(); match(); match();
    gap();
    check("gap_hit", 32'(hit), 32'h1);
    check("gap_run", 32'(run_cnt), 32'h4);
    check("gap_locked", 32'(locked), 32'h1);

    // Mismatch breaks a run
    do_clr();
    for (int i = 0; i < 3; i++) match();
    drive(1'b1, 8'hA5, 8'h5A, 8'hFF); cyc();
    for (int i = 0; i < 3; i++) match();
    gap();
    gap();
    check("break_nohit", 32'(hits), 32'h0);
    check("break_run3", 32'(run_cnt), 32'h3);
    check("break_locked", 32'(locked), 32'h0);
    check("break_total", 32'(total_cnt), 32'h6);

    // Saturation on the CNT_WIDTH=3 instance
    do_clr();
    for (int i = 0; i < 10; i++) match();
    gap();
    gap();
    check("sat_hits", 32'(hits_s), 32'h1);
    check("sat_run", 32'(run_s), 32'h7);
    check("sat_total", 32'(total_s), 32'h7);
    check("sat_locked", 32'(locked_s), 32'h1);
    check("main_total10", 32'(total_cnt), 32'hA);

    // clr wins over a simultaneous matching sample while LOCKED
    match();
    clr = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    cyc();
    clr = 1'b0;
    check("clr_run", 32'(run_cnt), 32'h0);
    check("clr_total0", 32'(total_cnt), 32'h0);
    check("clr_locked", 32'(locked), 32'h0);
    check("clr_lost", 32'(lost), 32'h0);
    check("clr_keeps_c", 32'(c), 32'hFF);
    gap();
    check("clr_lost_after", 32'(lost), 32'h0);

    // rst beats clr and en while LOCKED
    for (int i = 0; i < 4; i++) match();
    gap();
    check("relock", 32'(locked), 32'h1);
    match();
    rst = 1'b1; clr = 1'b1;
    drive(1'b1, 8'hA5, 8'hA5, 8'hFF);
    cyc();
    check("rst2_c", 32'(c), 32'h0);
    check("rst2_eq", 32'(eq), 32'h0);
    check("rst2_vld", 32'(vld), 32'h0);
    check("rst2_run", 32'(run_cnt), 32'h0);
    check("rst2_total", 32'(total_cnt), 32'h0);
    check("rst2_locked", 32'(locked), 32'h0);
    check("rst2_lost", 32'(lost), 32'h0);
    rst = 1'b0; clr = 1'b0;
    gap();
    check("rst2_lost_after", 32'(lost), 32'h0);
    check("rst2_run_after", 32'(run_cnt), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xnor_match_counter.md
# xnor_match_counter

Parametrised, registered successor to the single-bit XNOR equality gate. Compares two WIDTH-bit words every enabled cycle with a per-bit mask. Tracks runs of consecutive equal samples in a two-state lock FSM and keeps a saturating total of matches. Sits behind data sources that need pattern/sync-word lock detection, e.g. loopback checkers and sync-word detectors.

## Interface
- WIDTH, 8, compared word width (≥1)
- CNT_WIDTH, 8, width of run and total counters (≥2)
- THRESH, 4, consecutive matches required to lock (1 ≤ THRESH ≤ 2^CNT_WIDTH−1)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  sample valid; A, B, M are ignored when low
- clr  in  1  synchronous clear of counters and FSM (pipeline untouched)
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- M  in  WIDTH  care mask; bit = 0 means that bit is don't-care
- C  out  WIDTH  registered bitwise result ~(A^B) | ~M
- eq  out  1  registered: all cared bits equal (&C)
- vld  out  1  registered copy of en; qualifies C/eq
- run_cnt  out  CNT_WIDTH  consecutive-match count, saturating
- total_cnt  out  CNT_WIDTH  total matches since reset/clr, saturating
- locked  out  1  FSM in LOCKED
- hit  out  1  one-cycle pulse on SEARCH→LOCKED
- lost  out  1  one-cycle pulse on LOCKED→SEARCH

## Operation
- Stage 1, at every edge: vld←en. If en, C←~(A^B)|~M and eq←&(~(A^B)|~M). If !en, C and eq hold.
- Stage 2 acts at the edge after stage 1 and only when vld=1. vld=0 cycles are gaps: the FSM and counters hold, and a gap does not break a run.
- FSM states are SEARCH (reset state) and LOCKED.
- SEARCH, eq=1: run_cnt increments (saturating). If the new value equals THRESH: go to LOCKED and pulse hit.
- SEARCH, eq=0: run_cnt←0 and stay in SEARCH.
- LOCKED, eq=1: run_cnt increments (saturating) and stay in LOCKED.
- LOCKED, eq=0: run_cnt←0, go to SEARCH and pulse lost.
- total_cnt increments on every vld&eq, in either state.
- Both counters saturate at 2^CNT_WIDTH−1 with no wrap. Saturation never forces a state change.
- THRESH=1: the first match locks immediately.
- Fully masked word (M=0): C is all ones and eq=1.
- hit and lost are low in every cycle where no transition occurs. They are never high together.
- clr=1: run_cnt←0, total_cnt←0, state←SEARCH, hit←0, lost←0.
  - clr has priority over a simultaneous vld; that stage-2 sample is discarded.
  - clr never pulses lost, even if the FSM was LOCKED.
  - Stage-1 registers are unaffected by clr.
- rst=1 has priority over everything, including clr and en.

## Timing
- Reset values (after any edge with rst=1): C=0, eq=0, vld=0, run_cnt=0, total_cnt=0, locked=0, hit=0, lost=0.
- Latency from input to C/eq/vld: 1 cycle.
- Latency from input to run_cnt, total_cnt, locked, hit and lost: 2 cycles.
- hit and lost are exactly one cycle wide.
- locked rises in the same cycle hit is high, and falls in the same cycle lost is high.
- rst mid-run or mid-lock returns to reset values at that edge. In-flight stage-1 data is dropped and no lost pulse is produced.
- en may toggle every cycle; there is no back-pressure.

## Test plan
- Reset and XNOR (WIDTH=8):
  - rst for 2 cycles → all outputs 0.
  - A=8'hA5, B=8'hA5, M=8'hFF, en=1 → next cycle C=8'hFF, eq=1, vld=1.
  - A=8'hA5, B=8'h5A → C=8'h00, eq=0.
- Mask: A=8'hF0, B=8'hFF, M=8'hF0 → C=8'hFF, eq=1. Same inputs with M=8'hFF → C=8'hF0, eq=0.
- Lock/unlock (THRESH=4):
  - 4 matching samples in consecutive cycles → 2 cycles after the 4th, hit=1 for one cycle, locked=1, run_cnt=4.
  - 1 mismatch → lost=1 for one cycle, locked=0, run_cnt=0, total_cnt=4.
- Gaps and break: match, en=0 for 3 cycles, match, match, match → lock on the 4th match with run_cnt=4. Separately, 3 matches, mismatch, 3 matches → no hit, run_cnt=3.
- Saturation (CNT_WIDTH=3, THRESH=7): 10 consecutive matches → hit once, run_cnt=7, total_cnt=7, locked stays 1.
- Clear/reset priority:
  - clr asserted while LOCKED, in the same cycle as vld&eq → run_cnt=0, total_cnt=0, locked=0, lost=0.
  - rst asserted together with clr and en in LOCKED → all reset values, no pulse.
